// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
// Holds the x0 index and a field extractor for packed per-port buses.
package rf_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREGS_DEF   = 32;
  localparam int ZERO_REG    = 0;
  localparam int MAX_PACK_W  = 512;
  localparam int MAX_FIELD_W = 64;

  // Returns field idx (width bits) of a packed vector, zero-extended to MAX_FIELD_W.
  function automatic logic [MAX_FIELD_W-1:0] unpack_field(
    input logic [MAX_PACK_W-1:0] vec,
    input int                    idx,
    input int                    width
  );
    logic [MAX_FIELD_W-1:0] mask;
    mask = ~({MAX_FIELD_W{1'b1}} << width);
    return MAX_FIELD_W'(vec >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: x0 check, WR1-over-WR0 bypass, then stored data/busy.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   rd_addr_i,
  input  logic            wr0_en_i,
  input  logic [AW-1:0]   wr0_addr_i,
  input  logic [XLEN-1:0] wr0_data_i,
  input  logic            wr1_en_i,
  input  logic [AW-1:0]   wr1_addr_i,
  input  logic [XLEN-1:0] wr1_data_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            mem_busy_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_busy_o
);

  always_comb begin
    rd_data_o = mem_data_i;
    rd_busy_o = mem_busy_i;
    if (rd_addr_i == AW'(ZERO_REG)) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end else if (wr1_en_i && (wr1_addr_i == rd_addr_i)) begin
      rd_data_o = wr1_data_i;
      rd_busy_o = 1'b0;
    end else if (wr0_en_i && (wr0_addr_i == rd_addr_i)) begin
      rd_data_o = wr0_data_i;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with per-register busy scoreboard.
// Two retire ports (port 1 wins on collision), one issue port, NRD bypassed read ports.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NRD*AW-1:0]   RD_ADDR,
  output logic [NRD*XLEN-1:0] RD_DATA,
  output logic [NRD-1:0]      RD_BUSY,
  input  logic                WR0_EN,
  input  logic [AW-1:0]       WR0_ADDR,
  input  logic [XLEN-1:0]     WR0_DATA,
  input  logic                WR1_EN,
  input  logic [AW-1:0]       WR1_ADDR,
  input  logic [XLEN-1:0]     WR1_DATA,
  input  logic                ISSUE_EN,
  input  logic [AW-1:0]       ISSUE_ADDR,
  input  logic [AW-1:0]       DBG_ADDR,
  output logic [XLEN-1:0]     DBG_DATA
);

  logic [XLEN-1:0]  data_q [NREGS];
  logic [XLEN-1:0]  data_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wr0_act, wr1_act, iss_act;
  logic byp0_en, byp1_en;

  assign wr0_act = WR0_EN   && (WR0_ADDR   != AW'(ZERO_REG));
  assign wr1_act = WR1_EN   && (WR1_ADDR   != AW'(ZERO_REG));
  assign iss_act = ISSUE_EN && (ISSUE_ADDR != AW'(ZERO_REG));

  // Writes are dropped during reset, so the bypass must not show them either.
  assign byp0_en = WR0_EN && !RESET;
  assign byp1_en = WR1_EN && !RESET;

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (wr0_act) begin
      data_d[WR0_ADDR] = WR0_DATA;
      busy_d[WR0_ADDR] = 1'b0;
    end
    if (wr1_act) begin
      data_d[WR1_ADDR] = WR1_DATA;
      busy_d[WR1_ADDR] = 1'b0;
    end
    // A newly issued producer outranks a retiring one on the same register.
    if (iss_act) begin
      busy_d[ISSUE_ADDR] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign DBG_DATA = data_q[DBG_ADDR];

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [MAX_FIELD_W-1:0]    addr_field;
    logic [MAX_FIELD_W-AW-1:0] addr_unused;
    logic [AW-1:0]             addr;
    logic [XLEN-1:0]           data;
    logic                      busy;

    assign addr_field  = unpack_field(MAX_PACK_W'(RD_ADDR), i, AW);
    assign addr        = addr_field[AW-1:0];
    assign addr_unused = addr_field[MAX_FIELD_W-1:AW];

    rf_read_port #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rd (
      .rd_addr_i (addr),
      .wr0_en_i  (byp0_en),
      .wr0_addr_i(WR0_ADDR),
      .wr0_data_i(WR0_DATA),
      .wr1_en_i  (byp1_en),
      .wr1_addr_i(WR1_ADDR),
      .wr1_data_i(WR1_DATA),
      .mem_data_i(data_q[addr]),
      .mem_busy_i(busy_q[addr]),
      .rd_data_o (data),
      .rd_busy_o (busy)
    );

    assign RD_DATA[i*XLEN +: XLEN] = data;
    assign RD_BUSY[i]              = busy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp (NRD=4, NREGS=16, XLEN=64).
module tb_reg_file_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NRD   = 4;
  localparam int AW    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr0_en, wr1_en, iss_en;
  logic [AW-1:0]       wr0_addr, wr1_addr, iss_addr, dbg_addr;
  logic [XLEN-1:0]     wr0_data, wr1_data, dbg_data;

  logic [XLEN-1:0] m_data [NREGS];
  logic            m_busy [NREGS];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .CLK(clk), .RESET(rst),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_BUSY(rd_busy),
    .WR0_EN(wr0_en), .WR0_ADDR(wr0_addr), .WR0_DATA(wr0_data),
    .WR1_EN(wr1_en), .WR1_ADDR(wr1_addr), .WR1_DATA(wr1_data),
    .ISSUE_EN(iss_en), .ISSUE_ADDR(iss_addr),
    .DBG_ADDR(dbg_addr), .DBG_DATA(dbg_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_data[r] = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic void ref_read(input logic [AW-1:0] a, output logic [63:0] d, output logic b);
    if (a == 0) begin
      d = '0; b = 1'b0;
    end else if (!rst && wr1_en && wr1_addr == a) begin
      d = wr1_data; b = 1'b0;
    end else if (!rst && wr0_en && wr0_addr == a) begin
      d = wr0_data; b = 1'b0;
    end else begin
      d = m_data[a]; b = m_busy[a];
    end
  endfunction

  function automatic logic [63:0] port_data(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    logic [63:0] ed;
    logic        eb;
    if (rst) model_clear();
    #1;
    for (int i = 0; i < NRD; i++) begin
      ref_read(rd_addr[i*AW +: AW], ed, eb);
      check($sformatf("rd_data%0d", i), port_data(i), ed);
      check($sformatf("rd_busy%0d", i), {63'b0, rd_busy[i]}, {63'b0, eb});
    end
    check("dbg_pre", dbg_data, m_data[dbg_addr]);
    @(posedge clk);
    if (!rst) begin
      if (wr0_en && wr0_addr != 0) begin m_data[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != 0) begin m_data[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    #1;
    check("dbg_post", dbg_data, m_data[dbg_addr]);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0; dbg_addr = '0;
    wr0_data = '0; wr1_data = '0; rd_addr = '0;
    model_clear();
    @(negedge clk);
    for (int i = 0; i < NRD; i++) set_rd(i, AW'(i + 1));
    dbg_addr = 4'd2;
    cycle();
    rst = 1'b0;

    // fill every register
    for (int r = 1; r < NREGS; r++) begin
      wr0_en = 1'b1; wr0_addr = AW'(r); wr0_data = 64'h1111_0000_0000_0000 * r + 64'(r);
      set_rd(0, AW'(r)); dbg_addr = AW'(r);
      cycle();
    end
    idle();

    // asynchronous reset between edges; concurrent write is lost
    rst = 1'b1; wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 64'd5;
    set_rd(0, 4'd3); set_rd(1, 4'd5); dbg_addr = 4'd3;
    #1;
    check("rst_rd0", port_data(0), 64'd0);
    check("rst_rd1", port_data(1), 64'd0);
    check("rst_dbg", dbg_data, 64'd0);
    cycle();
    rst = 1'b0; idle();
    cycle();
    check("rst_lost", dbg_data, 64'd0);

    // x0 hardwired
    wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 64'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 4'd0; dbg_addr = 4'd0;
    for (int i = 0; i < NRD; i++) set_rd(i, 4'd0);
    #1;
    for (int i = 0; i < NRD; i++) begin
      check("x0_rd", port_data(i), 64'd0);
      check("x0_busy", {63'b0, rd_busy[i]}, 64'd0);
    end
    cycle();
    check("x0_dbg", dbg_data, 64'd0);
    idle();

    // dual write bypass: port 1 wins
    wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 64'h11;
    wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 64'h22;
    set_rd(0, 4'd5); dbg_addr = 4'd5;
    #1;
    check("byp_rd", port_data(0), 64'h22);
    cycle();
    check("byp_dbg", dbg_data, 64'h22);
    idle();

    // scoreboard
    iss_en = 1'b1; iss_addr = 4'd7; set_rd(0, 4'd7); dbg_addr = 4'd7;
    cycle();
    idle();
    #1 check("sb_busy_n1", {63'b0, rd_busy[0]}, 64'd1);
    cycle();
    cycle();
    wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 64'h99;
    #1;
    check("sb_busy_n3", {63'b0, rd_busy[0]}, 64'd0);
    check("sb_data_n3", port_data(0), 64'h99);
    cycle();
    idle();
    #1 check("sb_busy_n4", {63'b0, rd_busy[0]}, 64'd0);
    cycle();

    // issue and write same register
    iss_en = 1'b1; iss_addr = 4'd9; wr0_en = 1'b1; wr0_addr = 4'd9; wr0_data = 64'h42;
    set_rd(1, 4'd9); dbg_addr = 4'd9;
    cycle();
    idle();
    #1;
    check("iw_busy", {63'b0, rd_busy[1]}, 64'd1);
    check("iw_dbg", dbg_data, 64'h42);
    cycle();

    // four parallel 64-bit reads
    for (int k = 0; k < 4; k++) begin
      wr1_en = 1'b1; wr1_addr = AW'(1 << k); wr1_data = 64'hA5A5_0000_0000_0000 | 64'(k * 7 + 1) << 40 | 64'(k);
      cycle();
    end
    idle();
    for (int k = 0; k < 4; k++) set_rd(k, AW'(1 << k));
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("par%0d", k), port_data(k), 64'hA5A5_0000_0000_0000 | 64'(k * 7 + 1) << 40 | 64'(k));
    cycle();

    // top address x15 must not disturb x7
    wr0_en = 1'b1; wr0_addr = 4'd15; wr0_data = 64'hF0F0_1234_5678_0F0F; dbg_addr = 4'd15;
    cycle();
    idle();
    check("alias_x15", dbg_data, 64'hF0F0_1234_5678_0F0F);
    dbg_addr = 4'd7;
    #1 check("alias_x7", dbg_data, 64'h99);
    cycle();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      wr0_en   = $urandom_range(0, 1) == 1;
      wr1_en   = $urandom_range(0, 2) == 0;
      iss_en   = $urandom_range(0, 1) == 1;
      wr0_addr = AW'($urandom_range(0, NREGS - 1));
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, NREGS - 1));
      iss_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom_range(0, NREGS - 1));
      wr0_data = {$urandom, $urandom};
      wr1_data = {$urandom, $urandom};
      dbg_addr = AW'($urandom_range(0, NREGS - 1));
      for (int i = 0; i < NRD; i++) begin
        case ($urandom_range(0, 3))
          0:       set_rd(i, wr0_addr);
          1:       set_rd(i, wr1_addr);
          default: set_rd(i, AW'($urandom_range(0, NREGS - 1)));
        endcase
      end
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
